// File: rtl/regfile_wr_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// regfile_wr_arbiter_pkg
//   Shared constants and types for the register-file write-port arbiter.
//   NREQ writers share one write port: ALU writeback, load unit, debug port.
//   Contents:
//     NREQ, DW, AW      - writer count, data width, register address width
//     GW                - width of a writer index / grant index
//     grant_idx_t       - writer index type (also the priority pointer type)
//     REQ_ALU/LOAD/DBG  - writer IDs
//     next_ptr()        - round-robin pointer advance with wrap to 0
// -----------------------------------------------------------------------------
package regfile_wr_arbiter_pkg;

   localparam int NREQ = 3;
   localparam int DW   = 8;
   localparam int AW   = 3;
   localparam int GW   = 2;

   typedef logic [GW-1:0] grant_idx_t;

   localparam grant_idx_t REQ_ALU  = 2'd0;
   localparam grant_idx_t REQ_LOAD = 2'd1;
   localparam grant_idx_t REQ_DBG  = 2'd2;

   // Pointer moves to the writer just after the one granted, so that writer
   // becomes lowest priority for the next arbitration.
   function automatic grant_idx_t next_ptr(input grant_idx_t idx);
      grant_idx_t nxt;
      if (idx >= grant_idx_t'(NREQ - 1)) begin
         nxt = '0;
      end else begin
         nxt = idx + 1'b1;
      end
      return nxt;
   endfunction

endpackage

// File: rtl/regfile_wr_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// regfile_wr_arbiter_rr_pick
//   Combinational round-robin picker. Searches valid[] starting at ptr and
//   wrapping modulo NREQ; the first set bit wins.
//   Ports:
//     valid     in  NREQ  per-writer request
//     ptr       in  GW    index with highest priority this cycle
//     grant     out NREQ  one-hot winner (all zero when nothing valid)
//     grant_idx out GW    index of the winner (0 when nothing valid)
//     grant_any out 1     some writer won
// -----------------------------------------------------------------------------
module regfile_wr_arbiter_rr_pick
   import regfile_wr_arbiter_pkg::*;
(
   input  logic [NREQ-1:0] valid,
   input  grant_idx_t      ptr,
   output logic [NREQ-1:0] grant,
   output grant_idx_t      grant_idx,
   output logic            grant_any
);

   localparam int CW = GW + 1;

   // cand_idx[k] is the writer examined at search position k: (ptr + k) mod NREQ.
   logic [CW-1:0] cand_sum [NREQ];
   grant_idx_t    cand_idx [NREQ];

   generate
      for (genvar gi = 0; gi < NREQ; gi++) begin : g_cand
         assign cand_sum[gi] = {1'b0, ptr} + CW'(gi);
         assign cand_idx[gi] = (cand_sum[gi] >= CW'(NREQ))
                               ? GW'(cand_sum[gi] - CW'(NREQ))
                               : GW'(cand_sum[gi]);
      end
   endgenerate

   always_comb begin
      grant     = '0;
      grant_idx = '0;
      grant_any = 1'b0;
      for (int k = 0; k < NREQ; k++) begin
         if (!grant_any && valid[cand_idx[k]]) begin
            grant_any             = 1'b1;
            grant_idx             = cand_idx[k];
            grant[cand_idx[k]]    = 1'b1;
         end
      end
   end

endmodule

// File: rtl/regfile_wr_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_wr_arbiter
//   Shares the register file's single synchronous write port between the ALU
//   writeback (0), load unit (1) and debug port (2) with round-robin
//   arbitration and a valid/ready handshake. The write port is driven from
//   registers, so a write granted at edge T is presented during cycle T+1 and
//   committed by the register file at edge T+1. That in-flight write is
//   forwarded onto both read ports.
//   Ports:
//     clk, rst              clock, synchronous active-high reset
//     req_valid/req_ready   per-writer handshake (ready is combinational)
//     req_addr, req_data    flattened per-writer address / data
//     rf_we/waddr/wdata     registered register-file write port
//     grant_id              writer behind the current rf_we (registered)
//     rd1_addr, rd2_addr    read addresses (also go to the register file)
//     rf_rdata1, rf_rdata2  raw register-file read data
//     rd1_data, rd2_data    read data with the pending write forwarded
// -----------------------------------------------------------------------------
module regfile_wr_arbiter
   import regfile_wr_arbiter_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic [NREQ-1:0]    req_valid,
   output logic [NREQ-1:0]    req_ready,
   input  logic [NREQ*AW-1:0] req_addr,
   input  logic [NREQ*DW-1:0] req_data,
   output logic               rf_we,
   output logic [AW-1:0]      rf_waddr,
   output logic [DW-1:0]      rf_wdata,
   output logic [1:0]         grant_id,
   input  logic [AW-1:0]      rd1_addr,
   input  logic [AW-1:0]      rd2_addr,
   input  logic [DW-1:0]      rf_rdata1,
   input  logic [DW-1:0]      rf_rdata2,
   output logic [DW-1:0]      rd1_data,
   output logic [DW-1:0]      rd2_data
);

   // ---------------------------------------------------------------------------
   // Unpack the flattened writer buses
   // ---------------------------------------------------------------------------
   logic [AW-1:0] wr_addr [NREQ];
   logic [DW-1:0] wr_data [NREQ];

   generate
      for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
         assign wr_addr[gi] = req_addr[gi*AW +: AW];
         assign wr_data[gi] = req_data[gi*DW +: DW];
      end
   endgenerate

   // ---------------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------------
   grant_idx_t    ptr_q,      ptr_d;
   logic          rf_we_q,    rf_we_d;
   logic [AW-1:0] rf_waddr_q, rf_waddr_d;
   logic [DW-1:0] rf_wdata_q, rf_wdata_d;
   grant_idx_t    grant_id_q, grant_id_d;

   // ---------------------------------------------------------------------------
   // Arbitration
   // ---------------------------------------------------------------------------
   logic [NREQ-1:0] pick_grant;
   grant_idx_t      pick_idx;
   logic            pick_any;
   logic            handshake;

   regfile_wr_arbiter_rr_pick u_rr_pick (
      .valid     (req_valid),
      .ptr       (ptr_q),
      .grant     (pick_grant),
      .grant_idx (pick_idx),
      .grant_any (pick_any)
   );

   // Ready is withheld during reset so no writer believes it transferred a
   // write that the write stage is about to discard.
   assign req_ready = rst ? '0 : pick_grant;
   assign handshake = pick_any && !rst;

   always_comb begin
      ptr_d      = ptr_q;
      rf_we_d    = 1'b0;
      rf_waddr_d = rf_waddr_q;
      rf_wdata_d = rf_wdata_q;
      grant_id_d = grant_id_q;
      if (handshake) begin
         ptr_d      = next_ptr(pick_idx);
         rf_we_d    = 1'b1;
         rf_waddr_d = wr_addr[pick_idx];
         rf_wdata_d = wr_data[pick_idx];
         grant_id_d = pick_idx;
      end
   end

   // A write presented in the reset cycle still shows rf_we=1 for that cycle,
   // so the register file commits it at the same edge these registers clear.
   always_ff @(posedge clk) begin
      if (rst) begin
         ptr_q      <= '0;
         rf_we_q    <= 1'b0;
         rf_waddr_q <= '0;
         rf_wdata_q <= '0;
         grant_id_q <= '0;
      end else begin
         ptr_q      <= ptr_d;
         rf_we_q    <= rf_we_d;
         rf_waddr_q <= rf_waddr_d;
         rf_wdata_q <= rf_wdata_d;
         grant_id_q <= grant_id_d;
      end
   end

   assign rf_we    = rf_we_q;
   assign rf_waddr = rf_waddr_q;
   assign rf_wdata = rf_wdata_q;
   assign grant_id = grant_id_q;

   // ---------------------------------------------------------------------------
   // Forwarding: the register file only holds the pending write after the
   // next edge, so a read of that address this cycle must see the new data.
   // ---------------------------------------------------------------------------
   assign rd1_data = (rf_we_q && (rf_waddr_q == rd1_addr)) ? rf_wdata_q : rf_rdata1;
   assign rd2_data = (rf_we_q && (rf_waddr_q == rd2_addr)) ? rf_wdata_q : rf_rdata2;

endmodule

// File: doc/regfile_wr_arbiter.md
# regfile_wr_arbiter

Shares the register file's single synchronous write port between three writers: ALU writeback, load unit and debug port. Uses round-robin arbitration with a valid/ready handshake, and drives the register file's write port from registered outputs. Because a granted write lands one cycle late, the block also forwards that in-flight write onto both read ports. It sits between the CPU's writeback sources and the register file.

## Interface
- `NREQ`, 3: number of writers; index 0 = ALU, 1 = load unit, 2 = debug.
- `DW`, 8: data width.
- `AW`, 3: register address width.

- `clk` input 1: single clock, rising edge.
- `rst` input 1: synchronous, active-high reset.
- `req_valid` input NREQ: per-writer write request.
- `req_ready` output NREQ: per-writer grant; the write transfers when `valid && ready`.
- `req_addr` input NREQ*AW: flattened; writer i occupies bits [i*AW +: AW].
- `req_data` input NREQ*DW: flattened; writer i occupies bits [i*DW +: DW].
- `rf_we` output 1: write enable to the register file (registered).
- `rf_waddr` output AW: write address to the register file (registered).
- `rf_wdata` output DW: write data to the register file (registered).
- `grant_id` output 2: index of the writer behind the current `rf_we` (registered).
- `rd1_addr`, `rd2_addr` input AW: read addresses, also driven to the register file.
- `rf_rdata1`, `rf_rdata2` input DW: raw asynchronous read data from the register file.
- `rd1_data`, `rd2_data` output DW: forwarded read data.

## Operation
**Arbitration**
- Priority pointer `ptr` ranges 0..NREQ-1.
- The winner is the first i with `req_valid[i]`, searching ptr, ptr+1, … modulo NREQ.
- `req_ready` is combinational and one-hot: exactly the winner; all zeros when no writer is valid.
- After a grant to i, `ptr` <= (i+1) mod NREQ; wrap from NREQ-1 goes to 0.
- When no writer is valid, `ptr` holds.

**Writer rules**
- Once asserted, `req_valid`, `req_addr` and `req_data` stay stable until the handshake.
- `valid` must not depend on `ready`.
- A writer may issue back-to-back requests. It is re-granted only after every other valid writer has been served once.

**Write stage**
- On a handshake at edge T: `rf_we`=1, `rf_waddr`/`rf_wdata` = the winner's address/data, `grant_id` = winner index, all during cycle T+1.
- The register file commits the write at edge T+1.
- With no handshake at edge T, `rf_we`=0 in cycle T+1. `rf_waddr`, `rf_wdata` and `grant_id` hold their previous values.

**Forwarding (combinational)**
- `rd1_data` = `rf_wdata` when `rf_we` && `rf_waddr == rd1_addr`; otherwise `rf_rdata1`. `rd2_data` works the same way.
- Both ports may forward in the same cycle.

**Boundary cases**
- Two writers targeting the same address in one cycle: serialized in round-robin order; the later grant's data is final.
- All writers valid continuously: grants follow ptr, ptr+1, ptr+2, … with one write per cycle.
- Register 0 is not special; it is writable like any other.

## Timing
- Reset values: `ptr`=0, `rf_we`=0, `rf_waddr`=0, `rf_wdata`=0, `grant_id`=0.
- `req_ready` is forced to 0 while `rst` is high.
- Reset asserted in cycle T+1 while a write is pending: `rf_we` reads 1 during that cycle, so the register file still commits the pending write at edge T+1. The block's own outputs clear at that same edge. Writes not yet granted are dropped.
- Grant-to-commit latency: the handshake edge plus one cycle.
- Throughput: one write per cycle.
- Combinational paths: `req_valid` → `req_ready`, and read address/data → forwarded data.
- There is no combinational path from `req_*` to `rf_*`.

## Structure
- Shared package holds `NREQ`, `DW`, `AW`, writer IDs `REQ_ALU`=0, `REQ_LOAD`=1, `REQ_DBG`=2, and a grant-index typedef.
- Sub-module `rr_pick`: combinational round-robin picker taking `valid` and `ptr`, producing a one-hot grant and the grant index. The top level holds `ptr`, the write-stage registers and the forwarding muxes.

## Test plan
- **Single writer:** after reset, ALU valid with addr 3, data 0x5A. `req_ready`=001 that cycle; next cycle `rf_we`=1, `rf_waddr`=3, `rf_wdata`=0x5A, `grant_id`=0. One cycle after that, `rf_we`=0.
- **Round-robin:** all three writers held valid with distinct data. Grants follow 0,1,2,0,1,2 on consecutive cycles, and `rf_we` stays high continuously from the second cycle.
- **Same-address conflict:** ALU writes addr 5 = 0x11 and load writes addr 5 = 0x22 in the same cycle with `ptr`=0. The register file sees 0x11 then 0x22, and register 5 ends at 0x22.
- **Forwarding:** the pending write addr 2 = 0xC3 is in the write stage, `rd1_addr`=2, `rd2_addr`=4, `rf_rdata1`=0x00. `rd1_data`=0xC3 and `rd2_data`=`rf_rdata2`. A repeat with both read addresses at 2 gives 0xC3 on both ports.
- **Reset mid-stream:** writers streaming, then `rst` asserted for 1 cycle. The following cycle shows `rf_we`=0, `ptr`=0 and `req_ready`=0 during reset. The first grant after release goes to the lowest valid index.
